// File: rtl/sipo_loader_pkg.sv
// Shared types and helpers for the SIPO vector loader.
`default_nettype none

package sipo_loader_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOW_BYTE  = 2'd1,
      HIGH_BYTE = 2'd2,
      DONE      = 2'd3
   } loader_state_e;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/loader_timeout_ctr.sv
// Idle-gap watchdog: counts cycles while run_i is high, pulses expire_o at TIMEOUT_CYCLES.
`default_nettype none

module loader_timeout_ctr
   import sipo_loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int CW = cnt_w(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q;

   // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle; a clear that cycle wins.
   assign expire_o = run_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear_i || !run_i) begin
         cnt_q <= '0;
      end else if (!expire_o) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/sipo_vector_loader.sv
// Packs UART byte pairs into IWIDTH-bit elements and feeds NINPUTS of them to a SIPO.
// Optional byte-gap timeout enabled by defining LOADER_TIMEOUT_EN.
`default_nettype none

module sipo_vector_loader
   import sipo_loader_pkg::*;
#(
   parameter int IWIDTH         = 10,
   parameter int NINPUTS        = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [BYTE_W-1:0]           rx_data,
   input  logic                        rx_valid,
   output logic                        shift_en,
   output logic [IWIDTH-1:0]           shift_data,
   output logic                        busy,
   output logic                        vec_done,
   output logic [cnt_w(NINPUTS)-1:0]   elem_count,
   output logic                        timeout
);

   localparam int EW = cnt_w(NINPUTS);

   if (IWIDTH < 9 || IWIDTH > 16 || NINPUTS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("sipo_vector_loader: illegal parameter combination");
   end

   loader_state_e     state_q;
   logic [BYTE_W-1:0] low_q;
   logic [IWIDTH-1:0] shift_data_q;
   logic              shift_en_q;
   logic              vec_done_q;
   logic              timeout_q;
   logic [EW-1:0]     elem_count_q;
   logic [EW-1:0]     elem_count_d;
   logic              byte_acc;
   logic              timeout_hit;

   assign elem_count_d = elem_count_q + EW'(1);
   assign byte_acc     = rx_valid && ((state_q == LOW_BYTE) || (state_q == HIGH_BYTE));

`ifdef LOADER_TIMEOUT_EN
   logic got_byte_q;
   logic tmo_clear;
   logic tmo_run;

   // Silence before the first byte of a vector is never a timeout.
   assign tmo_clear = abort || byte_acc || (state_q == IDLE);
   assign tmo_run   = got_byte_q && ((state_q == LOW_BYTE) || (state_q == HIGH_BYTE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         got_byte_q <= 1'b0;
      end else if (abort || (state_q == IDLE)) begin
         got_byte_q <= 1'b0;
      end else if (byte_acc) begin
         got_byte_q <= 1'b1;
      end
   end

   loader_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (tmo_clear),
      .run_i    (tmo_run),
      .expire_o (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         low_q        <= '0;
         shift_data_q <= '0;
         shift_en_q   <= 1'b0;
         vec_done_q   <= 1'b0;
         timeout_q    <= 1'b0;
         elem_count_q <= '0;
      end else begin
         shift_en_q <= 1'b0;
         vec_done_q <= 1'b0;
         timeout_q  <= 1'b0;
         if (abort) begin
            state_q      <= IDLE;
            elem_count_q <= '0;
         end else if (timeout_hit) begin
            state_q      <= IDLE;
            elem_count_q <= '0;
            timeout_q    <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     state_q      <= LOW_BYTE;
                     elem_count_q <= '0;
                  end
               end
               LOW_BYTE: begin
                  if (rx_valid) begin
                     low_q   <= rx_data;
                     state_q <= HIGH_BYTE;
                  end
               end
               HIGH_BYTE: begin
                  if (rx_valid) begin
                     shift_data_q <= {rx_data[IWIDTH-BYTE_W-1:0], low_q};
                     shift_en_q   <= 1'b1;
                     elem_count_q <= elem_count_d;
                     state_q      <= (elem_count_d == EW'(NINPUTS)) ? DONE : LOW_BYTE;
                  end
               end
               DONE: begin
                  vec_done_q <= 1'b1;
                  state_q    <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign shift_en   = shift_en_q;
   assign shift_data = shift_data_q;
   assign busy       = (state_q != IDLE);
   assign vec_done   = vec_done_q;
   assign elem_count = elem_count_q;
   assign timeout    = timeout_q;

endmodule

`default_nettype wire
